// File: rtl/exec_sequencer.sv
// Execute stage for the 6502 load/store/transfer/inc-dec/branch/jump subset, fed by the fetcher.
// Optional macro EXEC_ILLEGAL_TRAP_EN: unsupported opcodes halt with sticky illegal_op instead of running as NOP.

`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE 16'h8000
`endif

module exec_sequencer #(
   parameter int unsigned REG_WIDTH  = `REG_WIDTH,
   parameter int unsigned ADDR_WIDTH = `ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(`INSTRUCTION_BASE)
) (
   input  logic                  phi1,
   input  logic                  reset_n,
   input  logic                  instruction_ready,
   input  logic [7:0]            instruction_in,
   input  logic [REG_WIDTH-1:0]  imm,
   input  logic [ADDR_WIDTH-1:0] op_addr,
   input  logic [ADDR_WIDTH-1:0] pc_next,
   input  logic [REG_WIDTH-1:0]  mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]  mem_wdata,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [REG_WIDTH-1:0]  a_reg,
   output logic [REG_WIDTH-1:0]  x_reg,
   output logic [REG_WIDTH-1:0]  y_reg,
   output logic                  flag_n,
   output logic                  flag_z,
   output logic                  instruction_done,
   output logic                  illegal_op
);

   localparam int unsigned OP_WIDTH = 8;

   typedef enum logic [3:0] {
      S_IDLE, S_EXEC, S_RD, S_WB, S_WR, S_JI_LO, S_JI_HI, S_DONE, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      C_IMPL, C_LDI, C_LDM, C_ST, C_BR, C_JABS, C_JIND, C_ILL
   } cls_e;

   // Opcode classification from the aaa/bbb/cc fields, exact codes taking priority
   function automatic cls_e decode_op(input logic [OP_WIDTH-1:0] op);
      logic [2:0] aaa;
      logic [2:0] bbb;
      logic [1:0] cc;
      cls_e       c;
      aaa = op[7:5];
      bbb = op[4:2];
      cc  = op[1:0];
      c   = C_ILL;
      case (op)
         8'hE8, 8'hC8, 8'hCA, 8'h88, 8'hAA, 8'h8A, 8'hA8, 8'h98, 8'hEA: c = C_IMPL;
         8'hF0, 8'hD0: c = C_BR;
         8'h4C:        c = C_JABS;
         8'h6C:        c = C_JIND;
         default: begin
            if (cc == 2'b01) begin
               if (aaa == 3'b101)                        c = (bbb == 3'b010) ? C_LDI : C_LDM;
               else if (aaa == 3'b100 && bbb != 3'b010)  c = C_ST;
            end else if (cc == 2'b10 || cc == 2'b00) begin
               if (aaa == 3'b101) begin
                  if (bbb == 3'b000)  c = C_LDI;
                  else if (bbb[0])    c = C_LDM;
               end else if (aaa == 3'b100 && bbb[0] && bbb != 3'b111) begin
                  c = C_ST;
               end
            end
         end
      endcase
      return c;
   endfunction

   // cc selects the target register: 01 -> A, 10 -> X, 00 -> Y
   function automatic logic [1:0] reg_sel(input logic [OP_WIDTH-1:0] op);
      case (op[1:0])
         2'b01:   return 2'd0;
         2'b10:   return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   state_e                state_q, state_d;
   cls_e                  cls_q, cls_d;
   logic                  rdy_prev_q;
   logic [OP_WIDTH-1:0]   opcode_q, opcode_d;
   logic [REG_WIDTH-1:0]  imm_q, imm_d;
   logic [ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [REG_WIDTH-1:0]  a_q, a_d, x_q, x_d, y_q, y_d;
   logic                  n_q, n_d, z_q, z_d;
   logic [REG_WIDTH-1:0]  lo_q, lo_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic                  mem_re_q, mem_re_d, mem_we_q, mem_we_d, done_q, done_d;
   logic                  accept;
   logic                  wr_en;
   logic [1:0]            wr_sel;
   logic [REG_WIDTH-1:0]  wr_val;

   assign accept    = instruction_ready && !rdy_prev_q && (state_q == S_IDLE);
   assign cls_d     = accept ? decode_op(instruction_in) : cls_q;
   assign opcode_d  = accept ? instruction_in : opcode_q;
   assign imm_d     = accept ? imm : imm_q;
   assign op_addr_d = accept ? op_addr : op_addr_q;

   always_ff @(posedge phi1 or negedge reset_n) begin : state_reg
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin : next_state_comb
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_EXEC;
         S_EXEC: begin
            case (cls_q)
               C_LDM:   state_d = S_RD;
               C_ST:    state_d = S_WR;
               C_JIND:  state_d = S_JI_LO;
`ifdef EXEC_ILLEGAL_TRAP_EN
               C_ILL:   state_d = S_HALT;
`endif
               default: state_d = S_DONE;
            endcase
         end
         S_RD:    state_d = S_WB;
         S_WB:    state_d = S_DONE;
         S_WR:    state_d = S_DONE;
         S_JI_LO: state_d = S_JI_HI;
         S_JI_HI: state_d = S_WB;
         S_DONE:  state_d = S_IDLE;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef EXEC_ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;
`endif

   // Datapath updates keyed on the current state, bus strobes keyed on the state being entered
   always_comb begin : output_comb
      pc_d        = pc_q;
      a_d         = a_q;
      x_d         = x_q;
      y_d         = y_q;
      n_d         = n_q;
      z_d         = z_q;
      lo_d        = lo_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      done_d      = 1'b0;
      wr_en       = 1'b0;
      wr_sel      = 2'd0;
      wr_val      = '0;
`ifdef EXEC_ILLEGAL_TRAP_EN
      illegal_d   = illegal_q;
`endif
      case (state_q)
         S_IDLE: pc_d = pc_next;
         S_EXEC: begin
            case (cls_q)
               C_IMPL: begin
                  wr_en = 1'b1;
                  case (opcode_q)
                     8'hE8:   begin wr_sel = 2'd1; wr_val = x_q + REG_WIDTH'(1); end
                     8'hC8:   begin wr_sel = 2'd2; wr_val = y_q + REG_WIDTH'(1); end
                     8'hCA:   begin wr_sel = 2'd1; wr_val = x_q - REG_WIDTH'(1); end
                     8'h88:   begin wr_sel = 2'd2; wr_val = y_q - REG_WIDTH'(1); end
                     8'hAA:   begin wr_sel = 2'd1; wr_val = a_q; end
                     8'h8A:   begin wr_sel = 2'd0; wr_val = x_q; end
                     8'hA8:   begin wr_sel = 2'd2; wr_val = a_q; end
                     8'h98:   begin wr_sel = 2'd0; wr_val = y_q; end
                     default: wr_en = 1'b0;
                  endcase
               end
               C_LDI: begin
                  wr_en  = 1'b1;
                  wr_sel = reg_sel(opcode_q);
                  wr_val = imm_q;
               end
               C_BR: begin
                  // BEQ taken on Z=1, BNE on Z=0; pc already holds the fetcher's advanced PC
                  if ((opcode_q == 8'hF0) == z_q) pc_d = pc_q + ADDR_WIDTH'($signed(imm_q));
               end
               C_JABS: pc_d = op_addr_q;
`ifdef EXEC_ILLEGAL_TRAP_EN
               C_ILL:  illegal_d = 1'b1;
`endif
               default: ;
            endcase
         end
         S_JI_HI: lo_d = mem_rdata;
         S_WB: begin
            if (cls_q == C_JIND) begin
               pc_d = ADDR_WIDTH'({mem_rdata, lo_q});
            end else begin
               wr_en  = 1'b1;
               wr_sel = reg_sel(opcode_q);
               wr_val = mem_rdata;
            end
         end
         default: ;
      endcase

      if (wr_en) begin
         case (wr_sel)
            2'd0:    a_d = wr_val;
            2'd1:    x_d = wr_val;
            default: y_d = wr_val;
         endcase
         n_d = wr_val[REG_WIDTH-1];
         z_d = (wr_val == '0);
      end

      case (state_d)
         S_EXEC: begin
            if (cls_d == C_LDM) begin
               mem_re_d   = 1'b1;
               mem_addr_d = op_addr_d;
            end
         end
         S_JI_LO: begin
            mem_re_d   = 1'b1;
            mem_addr_d = op_addr_q;
         end
         S_JI_HI: begin
            // Indirect pointer high byte stays on the same page (original 6502 behaviour)
            mem_re_d   = 1'b1;
            mem_addr_d = {op_addr_q[ADDR_WIDTH-1:8], op_addr_q[7:0] + 8'd1};
         end
         S_WR: begin
            mem_we_d   = 1'b1;
            mem_addr_d = op_addr_q;
            case (reg_sel(opcode_q))
               2'd0:    mem_wdata_d = a_q;
               2'd1:    mem_wdata_d = x_q;
               default: mem_wdata_d = y_q;
            endcase
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge phi1 or negedge reset_n) begin : datapath_reg
      if (!reset_n) begin
         cls_q       <= C_IMPL;
         rdy_prev_q  <= 1'b0;
         opcode_q    <= '0;
         imm_q       <= '0;
         op_addr_q   <= '0;
         pc_q        <= PC_RESET;
         a_q         <= '0;
         x_q         <= '0;
         y_q         <= '0;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         lo_q        <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cls_q       <= cls_d;
         rdy_prev_q  <= instruction_ready;
         opcode_q    <= opcode_d;
         imm_q       <= imm_d;
         op_addr_q   <= op_addr_d;
         pc_q        <= pc_d;
         a_q         <= a_d;
         x_q         <= x_d;
         y_q         <= y_d;
         n_q         <= n_d;
         z_q         <= z_d;
         lo_q        <= lo_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         done_q      <= done_d;
      end
   end

`ifdef EXEC_ILLEGAL_TRAP_EN
   always_ff @(posedge phi1 or negedge reset_n) begin : illegal_reg
      if (!reset_n) illegal_q <= 1'b0;
      else          illegal_q <= illegal_d;
   end
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign mem_re           = mem_re_q;
   assign mem_we           = mem_we_q;
   assign pc               = pc_q;
   assign a_reg            = a_q;
   assign x_reg            = x_q;
   assign y_reg            = y_q;
   assign flag_n           = n_q;
   assign flag_z           = z_q;
   assign instruction_done = done_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: scoreboard of expected architectural state per instruction.
module tb_exec_sequencer;

   localparam logic [15:0] PC_RST = 16'h8000;

   logic        phi1 = 1'b0;
   logic        reset_n;
   logic        instruction_ready;
   logic [7:0]  instruction_in;
   logic [7:0]  imm;
   logic [15:0] op_addr;
   logic [15:0] pc_next;
   logic [7:0]  mem_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_re, mem_we;
   logic [15:0] pc;
   logic [7:0]  a_reg, x_reg, y_reg;
   logic        flag_n, flag_z, instruction_done, illegal_op;

   exec_sequencer #(.REG_WIDTH(8), .ADDR_WIDTH(16), .PC_RESET(PC_RST)) dut (
      .phi1(phi1), .reset_n(reset_n), .instruction_ready(instruction_ready),
      .instruction_in(instruction_in), .imm(imm), .op_addr(op_addr), .pc_next(pc_next),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_we(mem_we), .pc(pc), .a_reg(a_reg), .x_reg(x_reg),
      .y_reg(y_reg), .flag_n(flag_n), .flag_z(flag_z),
      .instruction_done(instruction_done), .illegal_op(illegal_op)
   );

   always #5 phi1 = ~phi1;

   // Synchronous memory: read data appears the cycle after mem_re and is held
   logic [7:0] mem [0:65535];
   always @(posedge phi1) begin
      if (mem_re) mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   int checks = 0;
   int errors = 0;
   int we_total = 0;
   bit both_hi = 1'b0;

   always @(negedge phi1) begin
      if (reset_n === 1'b1 && mem_we === 1'b1) we_total++;
      if (reset_n === 1'b1 && mem_re === 1'b1 && mem_we === 1'b1) both_hi = 1'b1;
   end

   typedef struct {
      int          lat;
      logic [31:0] re_m;
      logic [31:0] we_m;
      logic [7:0]  a, x, y;
      logic        n, z;
      logic [15:0] pc;
   } exp_t;

   exp_t sb[$];

   logic [7:0] m_a = 8'h00, m_x = 8'h00, m_y = 8'h00;
   logic       m_n = 1'b0, m_z = 1'b0;

   task automatic run_instr(input logic [7:0] op, input logic [7:0] imm_v,
                            input logic [15:0] addr, input logic [15:0] pcn,
                            input logic [15:0] exp_pc, input int lat,
                            input logic [31:0] re_m, input logic [31:0] we_m,
                            input int hold);
      exp_t e, g;
      int cyc;
      int extra;
      bit got;
      logic [31:0] re_seen, we_seen;
      e.lat = lat; e.re_m = re_m; e.we_m = we_m;
      e.a = m_a; e.x = m_x; e.y = m_y; e.n = m_n; e.z = m_z; e.pc = exp_pc;
      sb.push_back(e);
      @(negedge phi1);
      instruction_in = op; imm = imm_v; op_addr = addr; pc_next = pcn;
      instruction_ready = 1'b1;
      cyc = 0; got = 1'b0; re_seen = '0; we_seen = '0;
      while (!got && cyc < 30) begin
         @(negedge phi1);
         cyc++;
         if (mem_re === 1'b1) re_seen[cyc] = 1'b1;
         if (mem_we === 1'b1) we_seen[cyc] = 1'b1;
         if (instruction_done === 1'b1) got = 1'b1;
      end
      g = sb.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL done_timeout op=%h: no done pulse within %0d cycles, required latency %0d", op, cyc, g.lat);
      end else begin
         if (cyc !== g.lat) begin
            errors++;
            $display("FAIL latency op=%h: got %0d required %0d", op, cyc, g.lat);
         end
         checks++;
         if ({a_reg, x_reg, y_reg, flag_n, flag_z} !== {g.a, g.x, g.y, g.n, g.z}) begin
            errors++;
            $display("FAIL regs op=%h: got A=%h X=%h Y=%h N=%b Z=%b required A=%h X=%h Y=%h N=%b Z=%b",
                     op, a_reg, x_reg, y_reg, flag_n, flag_z, g.a, g.x, g.y, g.n, g.z);
         end
         checks++;
         if (pc !== g.pc) begin
            errors++;
            $display("FAIL pc op=%h: got %h required %h", op, pc, g.pc);
         end
         checks++;
         if (re_seen !== g.re_m) begin
            errors++;
            $display("FAIL mem_re_cycles op=%h: got %h required %h", op, re_seen, g.re_m);
         end
         checks++;
         if (we_seen !== g.we_m) begin
            errors++;
            $display("FAIL mem_we_cycles op=%h: got %h required %h", op, we_seen, g.we_m);
         end
      end
      if (hold > 0) begin
         extra = 0;
         for (int i = 0; i < hold; i++) begin
            @(negedge phi1);
            if (instruction_done === 1'b1) extra++;
         end
         checks++;
         if (extra !== 0) begin
            errors++;
            $display("FAIL held_ready_retrigger op=%h: got %0d extra done pulses required 0", op, extra);
         end
      end
      instruction_ready = 1'b0;
      @(negedge phi1);
      checks++;
      if (instruction_done !== 1'b0) begin
         errors++;
         $display("FAIL done_one_cycle op=%h: got %b required 0", op, instruction_done);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; instruction_ready = 1'b0; instruction_in = 8'h00;
      imm = 8'h00; op_addr = 16'h0000; pc_next = 16'h0500;
      repeat (3) @(negedge phi1);
      checks++;
      if (pc !== PC_RST) begin errors++; $display("FAIL reset_pc: got %h required %h", pc, PC_RST); end
      checks++;
      if ({a_reg, x_reg, y_reg, flag_n, flag_z} !== 26'h0) begin
         errors++; $display("FAIL reset_regs: got %h required 0", {a_reg, x_reg, y_reg, flag_n, flag_z});
      end
      checks++;
      if ({mem_re, mem_we, instruction_done, illegal_op} !== 4'b0000) begin
         errors++; $display("FAIL reset_strobes: got %b required 0000", {mem_re, mem_we, instruction_done, illegal_op});
      end
      checks++;
      if ({mem_addr, mem_wdata} !== 24'h0) begin
         errors++; $display("FAIL reset_bus: got %h required 0", {mem_addr, mem_wdata});
      end
      reset_n = 1'b1;
      @(negedge phi1);
      checks++;
      if (pc !== 16'h0500) begin errors++; $display("FAIL idle_pc_follow: got %h required 0500", pc); end
   endtask

   task automatic test_reset_mid_load();
      int seen;
      m_a = 8'h11; m_n = 1'b0; m_z = 1'b0;
      run_instr(8'hA9, 8'h11, 16'h0000, 16'h0500, 16'h0500, 2, 32'h0, 32'h0, 0);
      mem[16'h0300] = 8'h77;
      @(negedge phi1);
      instruction_in = 8'hAD; op_addr = 16'h0300; pc_next = 16'h0520; instruction_ready = 1'b1;
      @(negedge phi1);
      checks++;
      if (mem_re !== 1'b1) begin errors++; $display("FAIL midload_re_exec: got %b required 1", mem_re); end
      @(negedge phi1);
      reset_n = 1'b0;
      #1;
      checks++;
      if (pc !== PC_RST) begin errors++; $display("FAIL midload_pc: got %h required %h", pc, PC_RST); end
      checks++;
      if (a_reg !== 8'h00) begin errors++; $display("FAIL midload_a: got %h required 00", a_reg); end
      checks++;
      if (mem_re !== 1'b0) begin errors++; $display("FAIL midload_re: got %b required 0", mem_re); end
      instruction_ready = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge phi1);
         if (instruction_done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL midload_done: got %0d pulses required 0", seen); end
      reset_n = 1'b1;
      m_a = 8'h00; m_x = 8'h00; m_y = 8'h00; m_n = 1'b0; m_z = 1'b0;
      @(negedge phi1);
   endtask

   task automatic test_load();
      m_a = 8'h80; m_n = 1'b1; m_z = 1'b0;
      run_instr(8'hA9, 8'h80, 16'h0000, 16'h0500, 16'h0500, 2, 32'h0, 32'h0, 0);
      mem[16'h0200] = 8'h00;
      m_x = 8'h00; m_n = 1'b0; m_z = 1'b1;
      run_instr(8'hAE, 8'h00, 16'h0200, 16'h0503, 16'h0503, 4, 32'h2, 32'h0, 0);
   endtask

   task automatic test_inc_dec();
      m_x = 8'hFF; m_n = 1'b1; m_z = 1'b0;
      run_instr(8'hA2, 8'hFF, 16'h0000, 16'h0505, 16'h0505, 2, 32'h0, 32'h0, 0);
      m_x = 8'h00; m_n = 1'b0; m_z = 1'b1;
      run_instr(8'hE8, 8'h00, 16'h0000, 16'h0506, 16'h0506, 2, 32'h0, 32'h0, 0);
      m_y = 8'h00; m_n = 1'b0; m_z = 1'b1;
      run_instr(8'hA0, 8'h00, 16'h0000, 16'h0508, 16'h0508, 2, 32'h0, 32'h0, 0);
      m_y = 8'hFF; m_n = 1'b1; m_z = 1'b0;
      run_instr(8'h88, 8'h00, 16'h0000, 16'h0509, 16'h0509, 2, 32'h0, 32'h0, 0);
   endtask

   task automatic test_transfer();
      m_x = 8'h80; m_n = 1'b1; m_z = 1'b0;
      run_instr(8'hAA, 8'h00, 16'h0000, 16'h050A, 16'h050A, 2, 32'h0, 32'h0, 0);
      m_a = 8'hFF; m_n = 1'b1; m_z = 1'b0;
      run_instr(8'h98, 8'h00, 16'h0000, 16'h050B, 16'h050B, 2, 32'h0, 32'h0, 0);
   endtask

   task automatic test_branch();
      run_instr(8'hD0, 8'hF0, 16'h0000, 16'h0610, 16'h0600, 2, 32'h0, 32'h0, 0);
      run_instr(8'hF0, 8'hF0, 16'h0000, 16'h0610, 16'h0610, 2, 32'h0, 32'h0, 0);
   endtask

   task automatic test_jmp();
      run_instr(8'h4C, 8'h00, 16'h1357, 16'h0700, 16'h1357, 2, 32'h0, 32'h0, 0);
      mem[16'h02FF] = 8'h34; mem[16'h0200] = 8'h12; mem[16'h0300] = 8'h99;
      run_instr(8'h6C, 8'h00, 16'h02FF, 16'h0703, 16'h1234, 5, 32'hC, 32'h0, 0);
   endtask

   task automatic test_back_to_back_store();
      int we0;
      m_a = 8'h5A; m_n = 1'b0; m_z = 1'b0;
      run_instr(8'hA9, 8'h5A, 16'h0000, 16'h0800, 16'h0800, 2, 32'h0, 32'h0, 0);
      mem[16'h4000] = 8'h00;
      we0 = we_total;
      run_instr(8'h8D, 8'h00, 16'h4000, 16'h0803, 16'h0803, 3, 32'h0, 32'h4, 10);
      checks++;
      if (we_total - we0 !== 1) begin
         errors++; $display("FAIL store_pulses: got %0d required 1", we_total - we0);
      end
      checks++;
      if (mem[16'h4000] !== 8'h5A) begin
         errors++; $display("FAIL store_data: got %h required 5A", mem[16'h4000]);
      end
   endtask

   task automatic test_illegal();
`ifdef EXEC_ILLEGAL_TRAP_EN
      int seen;
      @(negedge phi1);
      instruction_in = 8'h02; op_addr = 16'h0000; pc_next = 16'h0900; instruction_ready = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge phi1);
         if (instruction_done === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL illegal_done: got %0d pulses required 0", seen); end
      checks++;
      if (illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b required 1", illegal_op); end
      instruction_ready = 1'b0;
`else
      run_instr(8'h02, 8'h00, 16'h0000, 16'h0900, 16'h0900, 2, 32'h0, 32'h0, 0);
      checks++;
      if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_flag: got %b required 0", illegal_op); end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_mid_load();
      test_load();
      test_inc_dec();
      test_transfer();
      test_branch();
      test_jmp();
      test_back_to_back_store();
      test_illegal();
      checks++;
      if (both_hi !== 1'b0) begin errors++; $display("FAIL re_we_overlap: got 1 required 0"); end
      checks++;
      if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left: got %0d required 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Execute stage directly downstream of the instruction fetcher. Accepts a decoded-ready opcode, operand immediate and effective address from the fetcher. Performs the load/store/transfer/increment/branch/jump subset of the 6502 ISA. Owns A/X/Y, the N/Z flags and the PC register, and returns instruction_done to restart fetch.

Parameters:
REG_WIDTH, `REG_WIDTH (8), data/register width
ADDR_WIDTH, `ADDR_WIDTH (16), address width
PC_RESET, `INSTRUCTION_BASE, PC value after reset

Ports:
phi1  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
instruction_ready  input  1  fetcher holds high from operand-complete until instruction_done
instruction_in  input  8  opcode (fetcher instruction_out)
imm  input  8  immediate / branch offset
op_addr  input  16  effective address from fetcher
pc_next  input  16  fetcher's advanced PC
mem_rdata  input  8  memory read data, valid one cycle after mem_re
mem_addr  output  16  memory address
mem_wdata  output  8  store data
mem_re  output  1  read strobe
mem_we  output  1  write strobe
pc  output  16  program counter to fetcher
a_reg, x_reg, y_reg  output  8 each  architectural registers
flag_n, flag_z  output  1 each  status flags
instruction_done  output  1  one-cycle completion pulse
illegal_op  output  1  sticky unsupported-opcode flag

Behaviour:
- Reset (async, any state): pc=PC_RESET; A/X/Y=0; N/Z=0; mem_re/mem_we/instruction_done/illegal_op=0; mem_addr=0, mem_wdata=0; state IDLE.
- Accept on rising edge of instruction_ready (ready=1 and ready_d=0). A held-high ready never re-triggers. Latch opcode/imm/op_addr at accept.
- In IDLE: pc <= pc_next every cycle. pc frozen in all other states.
- States: IDLE, EXEC, RD, WB, WR, JI_LO, JI_HI, DONE.
- Accept -> EXEC (cycle T+1). EXEC decodes:
  - Implied ops (INX E8, INY C8, DEX CA, DEY 88, TAX AA, TXA 8A, TAY A8, TYA 98, NOP EA): update register in EXEC, then DONE.
  - Load class (cc=01 aaa=101 LDA; cc=10 aaa=101 LDX; cc=00 aaa=101 LDY):
    - Immediate form (bbb=010 for cc01; bbb=000 for cc10/cc00) writes imm in EXEC, then DONE.
    - Otherwise EXEC drives mem_addr=op_addr, mem_re=1 -> RD (wait) -> WB captures mem_rdata -> DONE.
  - Store class (aaa=100, same cc mapping; excludes 89): EXEC -> WR. WR drives mem_addr=op_addr, mem_wdata=reg, mem_we=1 for exactly one cycle -> DONE.
  - BEQ F0 / BNE D0: in EXEC, if taken, pc <= pc_next + sign_extend(imm), mod 2^16. Otherwise pc unchanged. Then DONE.
  - JMP 4C: pc <= op_addr; DONE.
  - JMP 6C: JI_LO reads op_addr; JI_HI reads {op_addr[15:8], op_addr[7:0]+1}. Page-wrap bug reproduced: low byte wraps, high byte is not carried. pc <= {hi,lo}; DONE.
- Arithmetic: INC/DEC wrap mod 256 (FF+1=00, 00-1=FF). N=result[7], Z=(result==0) for loads, transfers, INC/DEC. Stores, branches and jumps leave flags unchanged.
- DONE: instruction_done=1 for one cycle -> IDLE. Latency from accept to done pulse:
  - implied/immediate/branch/JMP abs: 2 cycles
  - store: 3 cycles
  - memory load: 4 cycles
  - JMP ind: 5 cycles
- mem_re/mem_we are never both high; both are low outside their states.
- Unsupported opcode: see optional feature.

Optional Feature:
EXEC_ILLEGAL_TRAP_EN.
- Defined: unsupported opcode sets illegal_op=1 (sticky) and the block enters HALT. No done pulse; cleared only by reset_n.
- Undefined: unsupported opcode executes as NOP (2-cycle done pulse). illegal_op tied 0.

Test Plan:
- Reset mid-load (assert reset_n low in RD) -> pc=PC_RESET, A=00, mem_re=0 immediately, no done pulse.
- LDA imm (A9, imm=80) -> A=80, N=1, Z=0, done at T+2. Then LDX abs (AE, op_addr=0200, mem[0200]=00) -> X=00, Z=1, mem_re at T+1 only, done at T+4.
- X=FF, INX -> X=00, Z=1, N=0. Then DEY with Y=00 -> Y=FF, N=1.
- BNE (D0, Z=0, pc_next=0610, imm=F0) -> pc=0600. BEQ same operands with Z=0 -> pc stays 0610.
- JMP (6C, op_addr=02FF, mem[02FF]=34, mem[0200]=12, mem[0300]=99) -> pc=1234, done at T+5.
- Opcode 02 -> with macro: illegal_op=1, no done for 20 cycles. Without macro: done at T+2, registers unchanged. Also hold instruction_ready high for 10 cycles after STA (8D, op_addr=4000, A=5A) -> exactly one mem_we pulse writing 5A to 4000.
